wc_tile_sched: RTL
==================

// Module: wc_tile_sched
// PURPOSE
//  Stream-side scheduler for the pipelined Winograd WC core (9 in -> 6 out). It collects a
//  scalar sample stream, forms overlapping 9-sample tiles (stride 6, overlap 3), and launches
//  them into WC. It tracks WC latency, buffers results and returns them on a valid/ready port.
//  It sits between the line-buffer front end and the WC datapath.
// PARAMETERS
//  DW      10  input sample width (two's complement)
//  ZW      10  width of one WC output word
//  N_IN    9   samples per tile (WC D lanes)
//  N_OUT   6   outputs per tile = tile stride; overlap = N_IN-N_OUT = 3
//  LAT     6   WC launch-to-result latency in clk cycles (fully pipelined, no stall)
//  FIFO_D  4   result FIFO depth (>=1); also the in-flight credit count
// PORTS
//  clk        in   1          clock, rising edge
//  rst        in   1          synchronous, active-low reset
//  in_valid   in   1          sample valid
//  in_ready   out  1          sample accepted when in_valid&in_ready
//  in_data    in   DW         sample
//  in_last    in   1          final sample of a row
//  wc_d       out  N_IN*DW    tile to WC D; oldest sample in the MSB lane
//  wc_start   out  1          1-cycle pulse: wc_d is valid this cycle
//  wc_z       in   N_OUT*ZW   WC Z, sampled exactly LAT cycles after wc_start
//  out_valid  out  1          result tile available (FIFO non-empty)
//  out_ready  in   1          consumer accepts when out_valid&out_ready
//  out_data   out  N_OUT*ZW   FIFO head, wc_z packing unchanged
//  out_last   out  1          head tile is the last tile of its row
//  busy       out  1          FSM not in FILL, or tokens in flight, or FIFO non-empty
// BEHAVIOUR
//  Reset (rst==0 at edge): FSM=FILL, cnt=0, first=1, credits=FIFO_D, window/wc_d=0, token pipe
//   cleared, FIFO empty; wc_start=0, out_valid=0, out_last=0, in_ready=1 after reset.
//   Mid-operation reset drops tiles in flight and FIFO contents; the WC result of a dropped
//   token is never written.
//  need = first ? N_IN : N_OUT.
//  FILL: in_ready=1. On accept, shift window left by DW and insert in_data at the LSB lane; cnt++.
//   cnt==need after accept -> ISSUE. in_last accepted with cnt<need -> PAD.
//   Set row_end on any in_last accept.
//  PAD: in_ready=0; shift in one zero sample per cycle, cnt++; at cnt==need -> ISSUE.
//  ISSUE: in_ready=0. If credits>0: wc_d<=window, wc_start=1 for that cycle, credits--, push token
//   {row_end} into LAT-deep pipe, cnt=0, first<=row_end, row_end<=0, -> FILL. Otherwise hold
//   ISSUE, with wc_start=0 and the window unchanged.
//  No sample is accepted in the ISSUE cycle (>=1 bubble per tile). Throughput is 1 tile per need+1 cycles.
//  Token exits pipe LAT cycles after wc_start -> write {wc_z,last} to FIFO. Credits guarantee no overflow.
//  Credit return: +1 per out handshake. Issue and pop in the same cycle -> credits unchanged.
//  Credits never exceed FIFO_D.
//  FIFO is first-word-fall-through; out_data/out_last are stable while out_valid&!out_ready.
//  Scheduler does no arithmetic. Widths pass through; zero padding is a DW-bit 0.
// TESTING
//  1 Stream 2,-10,3,4,-13,-18,-16,-28,-11 -> 9th accept+1: wc_d=90'b0000000010_1111110110_..._1111110101,
//    one wc_start pulse; with WC attached, out_valid at start+LAT+1, out_data lanes 160,-380,-502,... (mod 2^10)
//  2 Continue with -19,-6,3,-9,-12,11 -> second wc_d = {-16,-28,-11,-19,-6,3,-9,-12,11}; first stays 0
//  3 4 samples then in_last -> 2 PAD cycles, tile ends {..,s3,0,0}; out_last=1 on that tile;
//    next row needs 9 fresh samples
//  4 out_ready=0, continuous input -> exactly FIFO_D wc_start pulses, then stuck in ISSUE with in_ready=0;
//    release out_ready -> one launch per pop
//  5 rst low while 2 tokens are in flight and FIFO holds 1 -> next cycle out_valid=0, credits=FIFO_D,
//    and the late wc_z is ignored
//  6 Pop and issue in the same cycle with credits=1 -> issue proceeds, credits stay 1, no FIFO overflow

Source files
------------

// File: rtl/wc_tile_sched.sv
// Stream-side tile scheduler for the Winograd WC core: builds overlapping 9-sample tiles,
// launches them under a credit scheme, and returns WC results through a small FWFT FIFO.
module wc_tile_sched #(
    parameter int DW     = 10,
    parameter int ZW     = 10,
    parameter int N_IN   = 9,
    parameter int N_OUT  = 6,
    parameter int LAT    = 6,
    parameter int FIFO_D = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DW-1:0]         in_data,
    input  logic                  in_last,
    output logic [N_IN*DW-1:0]    wc_d,
    output logic                  wc_start,
    input  logic [N_OUT*ZW-1:0]   wc_z,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N_OUT*ZW-1:0]   out_data,
    output logic                  out_last,
    output logic                  busy
);

    localparam int WW = N_IN * DW;
    localparam int OW = N_OUT * ZW;
    localparam int CW = $clog2(N_IN + 1);
    localparam int KW = $clog2(FIFO_D + 1);
    localparam int PW = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;

    typedef enum logic [1:0] {
        S_FILL,
        S_PAD,
        S_ISSUE
    } state_t;

    state_t state;
    state_t state_next;

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic [CW-1:0] need;
    logic          first;
    logic          row_end;
    logic [WW-1:0] window;
    logic [KW-1:0] credits;
    logic          wc_last;
    logic          issue;
    logic          pop;
    logic          push;

    logic [LAT-1:0] tok_v;
    logic [LAT-1:0] tok_last;

    logic [OW:0]   mem [FIFO_D];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [KW-1:0] fifo_cnt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_D - 1)) ? '0 : p + PW'(1);
    endfunction

    assign need    = first ? CW'(N_IN) : CW'(N_OUT);
    assign cnt_inc = cnt + CW'(1);
    assign issue   = (state == S_ISSUE) && (credits != '0);
    assign pop     = out_valid && out_ready;
    assign push    = tok_v[LAT-1];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            S_FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (cnt_inc == need) begin
                        state_next = S_ISSUE;
                    end else if (in_last) begin
                        state_next = S_PAD;
                    end
                end
            end
            S_PAD: begin
                if (cnt_inc == need) begin
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (credits != '0) begin
                    state_next = S_FILL;
                end
            end
            default: state_next = S_FILL;
        endcase
    end

    // Window keeps the overlap implicitly: only N_OUT new samples shift in between tiles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt      <= '0;
            first    <= 1'b1;
            row_end  <= 1'b0;
            window   <= '0;
            wc_d     <= '0;
            wc_start <= 1'b0;
            wc_last  <= 1'b0;
        end else begin
            wc_start <= 1'b0;
            case (state)
                S_FILL: begin
                    if (in_valid) begin
                        window <= {window[WW-DW-1:0], in_data};
                        cnt    <= cnt_inc;
                        if (in_last) begin
                            row_end <= 1'b1;
                        end
                    end
                end
                S_PAD: begin
                    window <= {window[WW-DW-1:0], {DW{1'b0}}};
                    cnt    <= cnt_inc;
                end
                S_ISSUE: begin
                    if (credits != '0) begin
                        wc_d     <= window;
                        wc_start <= 1'b1;
                        wc_last  <= row_end;
                        cnt      <= '0;
                        first    <= row_end;
                        row_end  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            credits <= KW'(FIFO_D);
        end else begin
            case ({issue, pop})
                2'b10:   credits <= credits - KW'(1);
                2'b01:   credits <= credits + KW'(1);
                default: ;
            endcase
        end
    end

    // Token pipe mirrors WC latency so wc_z is captured exactly LAT cycles after wc_start.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tok_v    <= '0;
            tok_last <= '0;
        end else begin
            tok_v[0]    <= wc_start;
            tok_last[0] <= wc_last;
            for (int i = 1; i < LAT; i++) begin
                tok_v[i]    <= tok_v[i-1];
                tok_last[i] <= tok_last[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && push) begin
            mem[wr_ptr] <= {wc_z, tok_last[LAT-1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + KW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - KW'(1);
                default: ;
            endcase
        end
    end

    assign out_valid = (fifo_cnt != '0);
    assign out_data  = mem[rd_ptr][OW:1];
    assign out_last  = out_valid && mem[rd_ptr][0];
    assign busy      = (state != S_FILL) || wc_start || (|tok_v) || out_valid;

endmodule
